// File: rtl/pc_update.sv
// Next-PC selection for fetch: resolves ret, call and conditional branches
// into a registered redirect target, redirect select and decision strobe.
module pc_update (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [2:0]  branch_cond,
  input  logic        call,
  input  logic [11:0] call_imm,
  input  logic [15:0] PC_in,
  input  logic [15:0] sign_ext,
  input  logic        alu_done,
  input  logic [2:0]  flags,
  input  logic        ret,
  input  logic [15:0] PC_stack_pointer,
  output logic [15:0] PC_update,
  output logic        PC_src,
  output logic        update_done
);

  typedef enum logic [2:0] {
    COND_NEQ    = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } cond_e;

  logic        w_z;
  logic        w_v;
  logic        w_n;
  logic        w_cond_true;
  logic [15:0] w_next_pc;
  logic        w_next_src;
  logic        w_next_done;

  logic [15:0] r_pc;
  logic        r_src;
  logic        r_done;

  assign w_z = flags[2];
  assign w_v = flags[1];
  assign w_n = flags[0];

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_cond_true = 1'b0;
    case (cond_e'(branch_cond))
      COND_NEQ:    w_cond_true = ~w_z;
      COND_EQ:     w_cond_true = w_z;
      COND_GT:     w_cond_true = ~w_z & ~w_n;
      COND_LT:     w_cond_true = w_n;
      COND_GTE:    w_cond_true = w_z | (~w_z & ~w_n);
      COND_LTE:    w_cond_true = w_n | w_z;
      COND_OVFL:   w_cond_true = w_v;
      COND_UNCOND: w_cond_true = 1'b1;
      default:     w_cond_true = 1'b0;
    endcase
  end

  // A branch without alu_done holds off: sequential fetch, no strobe, flags unused.
  always_comb begin
    w_next_pc   = PC_in;
    w_next_src  = 1'b0;
    w_next_done = 1'b0;
    if (ret) begin
      w_next_pc   = PC_stack_pointer;
      w_next_src  = 1'b1;
      w_next_done = 1'b1;
    end else if (call) begin
      w_next_pc   = {PC_in[15:12], call_imm};
      w_next_src  = 1'b1;
      w_next_done = 1'b1;
    end else if (branch && alu_done) begin
      w_next_done = 1'b1;
      if (w_cond_true) begin
        w_next_pc  = PC_in + sign_ext;
        w_next_src = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= 16'h0000;
      r_src  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_pc   <= w_next_pc;
      r_src  <= w_next_src;
      r_done <= w_next_done;
    end
  end

  assign PC_update   = r_pc;
  assign PC_src      = r_src;
  assign update_done = r_done;

endmodule

// File: tb/tb_pc_update.sv
// Self-checking bench for pc_update: directed corner cases plus randomized
// stimulus compared against a behavioural next-PC model.
module tb_pc_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [2:0]  branch_cond;
  logic        call;
  logic [11:0] call_imm;
  logic [15:0] PC_in;
  logic [15:0] sign_ext;
  logic        alu_done;
  logic [2:0]  flags;
  logic        ret;
  logic [15:0] PC_stack_pointer;
  logic [15:0] PC_update;
  logic        PC_src;
  logic        update_done;

  int n_checks = 0;
  int n_errors = 0;

  pc_update dut (
    .clk              (clk),
    .rst              (rst),
    .branch           (branch),
    .branch_cond      (branch_cond),
    .call             (call),
    .call_imm         (call_imm),
    .PC_in            (PC_in),
    .sign_ext         (sign_ext),
    .alu_done         (alu_done),
    .flags            (flags),
    .ret              (ret),
    .PC_stack_pointer (PC_stack_pointer),
    .PC_update        (PC_update),
    .PC_src           (PC_src),
    .update_done      (update_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic idle();
    branch = 1'b0; branch_cond = 3'b000; call = 1'b0; call_imm = 12'h000;
    PC_in = 16'h0000; sign_ext = 16'h0000; alu_done = 1'b0; flags = 3'b000;
    ret = 1'b0; PC_stack_pointer = 16'h0000;
  endtask

  // Waits for the next edge, then compares all three outputs.
  task automatic step_check(input string tag, input logic [15:0] pc, input logic src, input logic done);
    @(posedge clk);
    #1;
    check({tag, ".pc"},   {16'h0, PC_update},   {16'h0, pc});
    check({tag, ".src"},  {31'h0, PC_src},      {31'h0, src});
    check({tag, ".done"}, {31'h0, update_done}, {31'h0, done});
  endtask

  // Reference: returns {next_pc, src, done} straight from the decision rules.
  function automatic logic [17:0] ref_next(
    input logic r, input logic c, input logic b, input logic ad,
    input logic [2:0] cond, input logic [2:0] fl,
    input logic [15:0] pcin, input logic [15:0] se,
    input logic [11:0] imm, input logic [15:0] sp);
    bit z, v, n;
    bit holds [8];
    logic [15:0] target;
    z = fl[2]; v = fl[1]; n = fl[0];
    holds = '{!z, z, !z && !n, n, z || (!z && !n), n || z, v, 1'b1};
    target = pcin + se;
    if (r)       return {sp, 2'b11};
    if (c)       return {pcin[15:12], imm, 2'b11};
    if (b && ad) return holds[cond] ? {target, 2'b11} : {pcin, 2'b01};
    return {pcin, 2'b00};
  endfunction

  logic [17:0] exp_out;

  initial begin
    idle();
    rst = 1'b1;
    #1;
    check("reset.pc",   {16'h0, PC_update},   32'h0);
    check("reset.src",  {31'h0, PC_src},      32'h0);
    check("reset.done", {31'h0, update_done}, 32'h0);

    // Inputs are ignored while reset is held across an edge.
    ret = 1'b1; PC_stack_pointer = 16'h1234;
    @(posedge clk); #1;
    check("reset_hold.pc", {16'h0, PC_update}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Branch EQ taken / not taken.
    PC_in = 16'h0010; sign_ext = 16'h0005; branch = 1'b1; branch_cond = 3'b001;
    flags = 3'b100; alu_done = 1'b1;
    step_check("beq_taken", 16'h0015, 1'b1, 1'b1);
    @(negedge clk);
    flags = 3'b000;
    step_check("beq_not", 16'h0010, 1'b0, 1'b1);

    // Call target concatenation.
    @(negedge clk); idle();
    PC_in = 16'hA003; call = 1'b1; call_imm = 12'h123;
    step_check("call", 16'hA123, 1'b1, 1'b1);

    // Back-to-back call strobes.
    @(negedge clk);
    PC_in = 16'h5FFF; call_imm = 12'h0AB;
    step_check("call_b2b", 16'h50AB, 1'b1, 1'b1);

    // ret beats call and branch.
    @(negedge clk);
    ret = 1'b1; call = 1'b1; branch = 1'b1; alu_done = 1'b1; branch_cond = 3'b111;
    PC_stack_pointer = 16'h4444;
    step_check("ret_prio", 16'h4444, 1'b1, 1'b1);

    // Unconditional branch wraps modulo 2^16, then a pending branch waits.
    @(negedge clk); idle();
    PC_in = 16'hFFFE; sign_ext = 16'h0004; branch = 1'b1; branch_cond = 3'b111;
    alu_done = 1'b1;
    step_check("wrap", 16'h0002, 1'b1, 1'b1);
    @(negedge clk);
    alu_done = 1'b0; flags = 3'b111;
    step_check("pending", 16'hFFFE, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with non-zero outputs, arriving during a pending branch.
    @(negedge clk); idle();
    PC_in = 16'h2000; call = 1'b1; call_imm = 12'hFFF;
    step_check("pre_rst", 16'h2FFF, 1'b1, 1'b1);
    @(negedge clk); idle();
    PC_in = 16'h0300; sign_ext = 16'h0010; branch = 1'b1; branch_cond = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.pc",   {16'h0, PC_update},   32'h0);
    check("async_rst.src",  {31'h0, PC_src},      32'h0);
    check("async_rst.done", {31'h0, update_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    PC_in = 16'h0100;
    step_check("after_rst", 16'h0100, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      ret              = ($urandom_range(0, 7) == 0);
      call             = ($urandom_range(0, 5) == 0);
      branch           = ($urandom_range(0, 1) == 1);
      alu_done         = ($urandom_range(0, 1) == 1);
      branch_cond      = 3'($urandom_range(0, 7));
      flags            = 3'($urandom_range(0, 7));
      call_imm         = 12'($urandom);
      PC_in            = 16'($urandom);
      sign_ext         = 16'($urandom);
      PC_stack_pointer = 16'($urandom);
      exp_out = ref_next(ret, call, branch, alu_done, branch_cond, flags,
                         PC_in, sign_ext, call_imm, PC_stack_pointer);
      @(posedge clk); #1;
      check("random", {14'h0, PC_update, PC_src, update_done}, {14'h0, exp_out});
    end

    @(negedge clk); idle();
    step_check("final_idle", 16'h0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
